// File: rtl/memory_access.sv
// Memory-access (M) pipeline stage.
// Turns the M-stage instruction into a data-memory request, formats store
// data and byte enables, extracts and extends load data, stalls the upstream
// pipeline while the memory is busy, and owns the MEM/WB pipeline register.
module memory_access #(
    parameter int P_WIDTH    = 32,
    parameter int P_PC_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    // M-stage instruction
    input  logic                  i_valid_m,
    input  logic [P_WIDTH-1:0]    i_alu_result_m,
    input  logic [P_WIDTH-1:0]    i_write_data_m,
    input  logic                  i_mem_read_m,
    input  logic                  i_mem_write_m,
    input  logic [2:0]            i_funct3_m,
    input  logic [1:0]            i_resultsrc_m,
    input  logic                  i_regwrite_m,
    input  logic [4:0]            i_rd_m,
    input  logic [P_PC_WIDTH-1:0] i_pc_plus_4_m,

    // Data-memory request bus
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [P_WIDTH-1:0]    o_dmem_addr,
    output logic [P_WIDTH-1:0]    o_dmem_wdata,
    output logic [3:0]            o_dmem_be,
    input  logic                  i_dmem_ack,
    input  logic [P_WIDTH-1:0]    i_dmem_rdata,

    // Pipeline control
    output logic                  o_stall_m,
    output logic                  o_mem_err,

    // MEM/WB register
    output logic                  o_valid_w,
    output logic [P_WIDTH-1:0]    o_alu_result_w,
    output logic [P_WIDTH-1:0]    o_mem_data_w,
    output logic [P_PC_WIDTH-1:0] o_pc_plus_4_w,
    output logic [1:0]            o_resultsrc_w,
    output logic                  o_regwrite_w,
    output logic [4:0]            o_rd_w
);

    // Access size encoded in funct3[1:0]; funct3[2] selects zero extension.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    // Instruction decode
    logic [1:0] byte_off;
    logic [1:0] acc_size;
    logic       is_unsigned;
    logic       mem_op;
    logic       is_store;
    logic       is_load;
    logic       illegal_f3;
    logic       misaligned;
    logic       access_err;
    logic       legal_op;

    // Handshake control
    logic       req;
    logic       stall;
    logic       complete;

    // Data formatting
    logic [P_WIDTH-1:0] store_data;
    logic [3:0]         lane_be;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [P_WIDTH-1:0] load_data;

    // MEM/WB register
    logic                  valid_w_q, valid_w_d;
    logic [P_WIDTH-1:0]    alu_result_w_q, alu_result_w_d;
    logic [P_WIDTH-1:0]    mem_data_w_q, mem_data_w_d;
    logic [P_PC_WIDTH-1:0] pc_plus_4_w_q, pc_plus_4_w_d;
    logic [1:0]            resultsrc_w_q, resultsrc_w_d;
    logic                  regwrite_w_q, regwrite_w_d;
    logic [4:0]            rd_w_q, rd_w_d;

    // Decode the access: a store wins over a load when both are requested,
    // and illegal or misaligned accesses never reach the memory.
    always_comb begin
        byte_off    = i_alu_result_m[1:0];
        acc_size    = i_funct3_m[1:0];
        is_unsigned = i_funct3_m[2];
        mem_op      = i_valid_m & (i_mem_read_m | i_mem_write_m);
        is_store    = i_mem_write_m;
        is_load     = i_mem_read_m & ~i_mem_write_m;
        illegal_f3  = (i_funct3_m == 3'b011) | (i_funct3_m == 3'b110) |
                      (i_funct3_m == 3'b111);
        misaligned  = ((acc_size == SZ_HALF) & byte_off[0]) |
                      ((acc_size == SZ_WORD) & (byte_off != 2'b00));
        access_err  = mem_op & (illegal_f3 | misaligned);
        legal_op    = mem_op & ~access_err;
    end

    // Request handshake FSM: a request is issued straight from IDLE and only
    // parks in WAIT when the memory does not acknowledge in the same cycle.
    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (legal_op) begin
                    req = 1'b1;
                    if (i_dmem_ack) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (i_dmem_ack) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register; reset aborts any outstanding access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Store formatting: replicate the datum across all lanes and let the
    // byte enables pick the lane(s); loads enable the lanes they read.
    always_comb begin
        store_data = i_write_data_m;
        lane_be    = 4'b1111;
        case (acc_size)
            SZ_BYTE: begin
                store_data = {(P_WIDTH/8){i_write_data_m[7:0]}};
                lane_be    = 4'(4'b0001 << byte_off);
            end
            SZ_HALF: begin
                store_data = {(P_WIDTH/16){i_write_data_m[15:0]}};
                lane_be    = byte_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = i_write_data_m;
                lane_be    = 4'b1111;
            end
        endcase
    end

    // Load extraction: select the addressed lane of the aligned read word and
    // sign- or zero-extend it.
    always_comb begin
        ld_byte   = i_dmem_rdata[{byte_off, 3'b000} +: 8];
        ld_half   = i_dmem_rdata[{byte_off[1], 4'b0000} +: 16];
        load_data = i_dmem_rdata;
        case (acc_size)
            SZ_BYTE: begin
                load_data = is_unsigned ? {{(P_WIDTH-8){1'b0}}, ld_byte}
                                        : {{(P_WIDTH-8){ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                load_data = is_unsigned ? {{(P_WIDTH-16){1'b0}}, ld_half}
                                        : {{(P_WIDTH-16){ld_half[15]}}, ld_half};
            end
            default: begin
                load_data = i_dmem_rdata;
            end
        endcase
    end

    // Memory bus and pipeline control; reset drops the request and stall
    // immediately rather than waiting for the state register to settle.
    always_comb begin
        o_dmem_req   = req & i_rst_n;
        o_dmem_we    = req & i_rst_n & is_store;
        o_dmem_addr  = {i_alu_result_m[P_WIDTH-1:2], 2'b00};
        o_dmem_wdata = store_data;
        o_dmem_be    = (req & i_rst_n) ? lane_be : 4'b0000;
        o_stall_m    = stall & i_rst_n;
        o_mem_err    = access_err & (state_q == S_IDLE) & i_rst_n;
    end

    // MEM/WB next value: a bubble by default, the instruction itself when it
    // is valid, error-free and not held back by a memory stall.
    always_comb begin
        valid_w_d      = 1'b0;
        alu_result_w_d = '0;
        mem_data_w_d   = '0;
        pc_plus_4_w_d  = '0;
        resultsrc_w_d  = 2'b00;
        regwrite_w_d   = 1'b0;
        rd_w_d         = 5'd0;
        if (i_valid_m && !stall && !access_err) begin
            valid_w_d      = 1'b1;
            alu_result_w_d = i_alu_result_m;
            mem_data_w_d   = (complete && is_load) ? load_data : '0;
            pc_plus_4_w_d  = i_pc_plus_4_m;
            resultsrc_w_d  = i_resultsrc_m;
            regwrite_w_d   = i_regwrite_m;
            rd_w_d         = i_rd_m;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_w_q      <= 1'b0;
            alu_result_w_q <= '0;
            mem_data_w_q   <= '0;
            pc_plus_4_w_q  <= '0;
            resultsrc_w_q  <= 2'b00;
            regwrite_w_q   <= 1'b0;
            rd_w_q         <= 5'd0;
        end else begin
            valid_w_q      <= valid_w_d;
            alu_result_w_q <= alu_result_w_d;
            mem_data_w_q   <= mem_data_w_d;
            pc_plus_4_w_q  <= pc_plus_4_w_d;
            resultsrc_w_q  <= resultsrc_w_d;
            regwrite_w_q   <= regwrite_w_d;
            rd_w_q         <= rd_w_d;
        end
    end

    assign o_valid_w      = valid_w_q;
    assign o_alu_result_w = alu_result_w_q;
    assign o_mem_data_w   = mem_data_w_q;
    assign o_pc_plus_4_w  = pc_plus_4_w_q;
    assign o_resultsrc_w  = resultsrc_w_q;
    assign o_regwrite_w   = regwrite_w_q;
    assign o_rd_w         = rd_w_q;

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter P_WIDTH, default 32, which sets the data and address width.
REQ-002 SHALL have parameter P_PC_WIDTH, default 10, which sets the PC+4 width passed to writeback.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-005 SHALL have port i_valid_m, input, 1 bit: an instruction is present in the M stage.
REQ-006 SHALL have port i_alu_result_m, input, P_WIDTH bits: the effective address, or the ALU result for non-memory instructions.
REQ-007 SHALL have port i_write_data_m, input, P_WIDTH bits: store data.
REQ-008 SHALL have ports i_mem_read_m and i_mem_write_m, input, 1 bit each: load and store request.
REQ-009 SHALL have port i_funct3_m, input, 3 bits: access size and signedness.
REQ-010 SHALL have port i_resultsrc_m, input, 2 bits: writeback mux select, carried through unchanged.
REQ-011 SHALL have ports i_regwrite_m (1 bit), i_rd_m (5 bits) and i_pc_plus_4_m (P_PC_WIDTH bits), all inputs, carried through unchanged.
REQ-012 SHALL have outputs o_dmem_req (1), o_dmem_we (1), o_dmem_addr (P_WIDTH), o_dmem_wdata (P_WIDTH) and o_dmem_be (4): the data memory request bus.
REQ-013 SHALL have inputs i_dmem_ack (1) and i_dmem_rdata (P_WIDTH): memory completion and the aligned read word.
REQ-014 SHALL have output o_stall_m, 1 bit: upstream must hold all M inputs while it is high.
REQ-015 SHALL have output o_mem_err, 1 bit: one-cycle pulse for a misaligned access or an illegal funct3.
REQ-016 SHALL have registered outputs o_valid_w, o_alu_result_w, o_mem_data_w, o_pc_plus_4_w, o_resultsrc_w, o_regwrite_w and o_rd_w, which form the MEM/WB register.

Function
REQ-017 SHALL use FSM states IDLE and WAIT; a memory op is valid & (read | write); when both read and write are high, the write wins.
REQ-018 SHALL, in IDLE with a legal memory op, assert o_dmem_req combinationally in the same cycle; if i_dmem_ack=1 in that cycle, the access completes with no stall.
REQ-019 SHALL, in IDLE with a legal memory op and no ack, set o_stall_m=1 and enter WAIT at the clock edge.
REQ-020 SHALL, in WAIT, hold o_dmem_req=1 with addr/we/wdata/be stable and o_stall_m=1 until i_dmem_ack=1, then return to IDLE at that edge.
REQ-021 SHALL ignore i_dmem_ack whenever no request is outstanding.
REQ-022 SHALL drive o_dmem_addr = {i_alu_result_m[P_WIDTH-1:2], 2'b00}.
REQ-023 SHALL encode stores as: SB (000) = byte replicated to all four lanes with be=1<<addr[1:0]; SH (001) = halfword replicated with be=0011 if addr[1]=0, else 1100; SW (010) = be=1111.
REQ-024 SHALL extract loads as: LB/LBU (000/100) = byte lane addr[1:0], sign- or zero-extended; LH/LHU (001/101) = half lane addr[1], sign- or zero-extended; LW (010) = full word.
REQ-025 SHALL treat halfword access with addr[0]=1, word access with addr[1:0]≠0, or funct3 in {011, 110, 111} as an error.
REQ-026 SHALL, on an error: issue no request, no stall, pulse o_mem_err for 1 cycle, and load o_valid_w=0 and o_regwrite_w=0 at the next edge.
REQ-027 SHALL capture the MEM/WB register at the edge where the op completes, or every cycle for non-memory ops; o_mem_data_w = extracted load data, else 0.
REQ-028 SHALL, while o_stall_m=1, load a bubble into the MEM/WB register at each edge: o_valid_w=0, o_regwrite_w=0.
REQ-029 SHALL, for i_valid_m=0, capture o_valid_w=0 and o_regwrite_w=0 into the MEM/WB register.
REQ-030 SHALL give a load a latency of 1 edge after ack to reach o_mem_data_w.

Reset
REQ-031 SHALL, when i_rst_n=0, immediately set the FSM to IDLE and drive all registered outputs to 0.
REQ-032 SHALL, on reset in WAIT, abort the access and drop o_dmem_req asynchronously; the outstanding ack is ignored and there is no writeback.
REQ-033 SHALL accept a new op on the first edge after reset release.

Verification
REQ-034 SHALL test: LW, addr=0x100, rdata=0x8899AABB, ack in the same cycle -> no stall; the next edge gives o_mem_data_w=0x8899AABB and o_valid_w=1.
REQ-035 SHALL test: LB, addr=0x103, rdata=0x80000000, ack after 3 cycles -> o_stall_m=1 for 3 cycles with 3 bubbles, then o_mem_data_w=0xFFFFFF80; with LBU, 0x00000080.
REQ-036 SHALL test: SH, addr=0x202, wdata=0x1234ABCD -> o_dmem_wdata=0xABCDABCD, be=1100, we=1, addr=0x200.
REQ-037 SHALL test: LW, addr=0x101 -> o_mem_err pulses for 1 cycle, o_dmem_req=0 throughout, o_regwrite_w=0.
REQ-038 SHALL test: SB to 0x10 with ack delayed; i_rst_n=0 in WAIT -> o_dmem_req=0 immediately, all outputs 0; a later ack changes nothing.
REQ-039 SHALL test: ADD result 0x55, resultsrc=00, rd=7 -> the next edge gives o_alu_result_w=0x55, o_rd_w=7, o_mem_data_w=0, o_dmem_req=0.
